// File: rtl/sseg_scan_ctrl.sv
// Multiplexed NUM_DIGITS hex seven-segment scanner.
// Features: double-buffered loads, leading-zero blanking, 16-level PWM and selectable output polarity.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS     = 2,
  parameter int DIV_BITS       = 10,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  // Raw active-high {g,f,e,d,c,b,a} glyphs for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] v_seg;
    case (nib)
      4'h0:    v_seg = 7'b0111111;
      4'h1:    v_seg = 7'b0000110;
      4'h2:    v_seg = 7'b1011011;
      4'h3:    v_seg = 7'b1001111;
      4'h4:    v_seg = 7'b1100110;
      4'h5:    v_seg = 7'b1101101;
      4'h6:    v_seg = 7'b1111101;
      4'h7:    v_seg = 7'b0000111;
      4'h8:    v_seg = 7'b1111111;
      4'h9:    v_seg = 7'b1101111;
      4'hA:    v_seg = 7'b1110111;
      4'hB:    v_seg = 7'b1111100;
      4'hC:    v_seg = 7'b0111001;
      4'hD:    v_seg = 7'b1011110;
      4'hE:    v_seg = 7'b1111001;
      4'hF:    v_seg = 7'b1110001;
      default: v_seg = 7'b0000000;
    endcase
    return v_seg;
  endfunction

  logic [DIV_BITS-1:0]     r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_nib;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_nib;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_swap;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_blank;
  logic                    w_pwm_on;
  logic [NUM_DIGITS-1:0]   w_sel_raw;
  logic [6:0]              w_seg_raw;

  assign w_tick   = &r_div;
  assign w_swap   = w_tick && (r_idx == LAST_IDX);
  assign w_nib    = r_act_nib[{r_idx, 2'b00} +: 4];
  assign w_pwm_on = (r_div[DIV_BITS-1 -: 4] <= brightness);
  assign w_blank  = blank_lz && (r_idx != '0) && w_lz[r_idx];

  // Per-digit flag: this nibble and every more-significant nibble are zero.
  always_comb begin
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run   = v_run && (r_act_nib[4*i +: 4] == 4'h0);
      w_lz[i] = v_run;
    end
  end

  // Raw (active-high) digit enable and segment pattern for the current slot.
  always_comb begin
    w_sel_raw = '0;
    if (w_pwm_on) begin
      w_sel_raw[r_idx] = 1'b1;
    end else begin
      w_sel_raw = '0;
    end
    if (w_blank) begin
      w_seg_raw = 7'b0000000;
    end else begin
      w_seg_raw = hex_font(w_nib);
    end
  end

  // Free-running scan divider and digit index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div <= '0;
      r_idx <= '0;
    end else begin
      r_div <= r_div + DIV_BITS'(1);
      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Pending/active buffers; a swap copies the pre-edge pending value, so a coincident load lands next frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend_nib <= '0;
      r_pend_dp  <= '0;
      r_act_nib  <= '0;
      r_act_dp   <= '0;
      r_frame    <= 1'b0;
    end else begin
      if (load) begin
        r_pend_nib <= din;
        r_pend_dp  <= dp_in;
      end
      if (w_swap) begin
        r_act_nib <= r_pend_nib;
        r_act_dp  <= r_pend_dp;
      end
      r_frame <= w_swap;
    end
  end

  // Registered pin drivers with polarity applied.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
      r_sel <= {NUM_DIGITS{SEL_INV}};
    end else begin
      r_seg <= w_seg_raw ^ {7{SEG_INV}};
      r_dp  <= r_act_dp[r_idx] ^ SEG_INV;
      r_sel <= w_sel_raw ^ {NUM_DIGITS{SEL_INV}};
    end
  end

  assign seg_out   = r_seg;
  assign dp_out    = r_dp;
  assign digit_sel = r_sel;
  assign frame     = r_frame;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: a 4-digit active-low instance plus a 2-digit
// instance with inverted polarity, both on DIV_BITS=5.
module tb_sseg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic        frame;

  logic [7:0]  din_p;
  logic [1:0]  dp_in_p;
  logic        load_p;
  logic [6:0]  seg_p;
  logic        dp_out_p;
  logic [1:0]  sel_p;
  logic        frame_p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] cap_seg  [4];
  logic       cap_dp   [4];
  logic       cap_seen [4];
  logic       cap_first_frame;
  int         act_cnt;
  int         sel0_cnt;
  int         ncyc;

  sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV_BITS(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .brightness(brightness), .seg_out(seg_out),
    .dp_out(dp_out), .digit_sel(digit_sel), .frame(frame)
  );

  sseg_scan_ctrl #(.NUM_DIGITS(2), .DIV_BITS(5), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(1)) dut_p (
    .CLK(CLK), .RST_N(RST_N), .din(din_p), .dp_in(dp_in_p), .load(load_p),
    .blank_lz(blank_lz), .brightness(brightness), .seg_out(seg_p),
    .dp_out(dp_out_p), .digit_sel(sel_p), .frame(frame_p)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      if (frame) found = 1'b1;
    end
    check_eq("frame_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic capture_frame();
    logic [3:0] onehot;
    act_cnt  = 0;
    sel0_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      cap_seg[d]  = 7'h00;
      cap_dp[d]   = 1'b0;
      cap_seen[d] = 1'b0;
    end
    for (int c = 0; c < 128; c++) begin
      @(negedge CLK);
      if (c == 0) cap_first_frame = frame;
      for (int d = 0; d < 4; d++) begin
        onehot = 4'b0001 << d;
        if (digit_sel == onehot) begin
          cap_seg[d]  = seg_out;
          cap_dp[d]   = dp_out;
          cap_seen[d] = 1'b1;
        end
      end
      if (digit_sel != 4'h0) act_cnt++;
      if (digit_sel == 4'b0001) sel0_cnt++;
    end
  endtask

  task automatic load_main(input logic [15:0] d, input logic [3:0] dp);
    din   = d;
    dp_in = dp;
    load  = 1'b1;
    @(negedge CLK);
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       found_p;
    logic       seen1_p;
    logic [6:0] p_seg0;
    logic [6:0] p_seg1;
    logic       p_dp1;

    RST_N      = 1'b0;
    din        = 16'h0000;
    dp_in      = 4'h0;
    load       = 1'b0;
    blank_lz   = 1'b0;
    brightness = 4'd15;
    din_p      = 8'h8A;
    dp_in_p    = 2'b00;
    load_p     = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);

    // Asynchronous reset in the middle of a scan
    #2 RST_N = 1'b0;
    #1;
    check_eq("rst_seg",    {25'd0, seg_out},   32'h7F);
    check_eq("rst_dp",     {31'd0, dp_out},    32'd1);
    check_eq("rst_sel",    {28'd0, digit_sel}, 32'h0);
    check_eq("rst_frame",  {31'd0, frame},     32'd0);
    check_eq("rst_p_seg",  {25'd0, seg_p},     32'h00);
    check_eq("rst_p_sel",  {30'd0, sel_p},     32'h3);
    check_eq("rst_p_dp",   {31'd0, dp_out_p},  32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    wait_frame(ncyc);
    check_eq("first_frame_cycle", ncyc, 32'd128);
    capture_frame();
    check_eq("frame_one_cycle", {31'd0, cap_first_frame}, 32'd0);
    check_eq("idle_seg0", {25'd0, cap_seg[0]}, 32'h40);
    check_eq("idle_seg3", {25'd0, cap_seg[3]}, 32'h40);
    check_eq("idle_dp0",  {31'd0, cap_dp[0]},  32'd1);

    // Load then swap
    load_main(16'h12AF, 4'b0100);
    wait_frame(ncyc);
    capture_frame();
    check_eq("ld_seen0", {31'd0, cap_seen[0]}, 32'd1);
    check_eq("ld_seg0",  {25'd0, cap_seg[0]}, {25'd0, ~7'b1110001});
    check_eq("ld_dp0",   {31'd0, cap_dp[0]},  32'd1);
    check_eq("ld_seg1",  {25'd0, cap_seg[1]}, {25'd0, ~7'b1110111});
    check_eq("ld_seg2",  {25'd0, cap_seg[2]}, {25'd0, ~7'b1011011});
    check_eq("ld_dp2",   {31'd0, cap_dp[2]},  32'd0);
    check_eq("ld_seg3",  {25'd0, cap_seg[3]}, {25'd0, ~7'b0000110});

    // Load coincident with the swap edge: old pending shows first
    load_main(16'h1111, 4'b0000);
    repeat (126) @(negedge CLK);
    din  = 16'h2222;
    load = 1'b1;
    @(negedge CLK);
    check_eq("swap_edge_frame", {31'd0, frame}, 32'd1);
    load = 1'b0;
    capture_frame();
    check_eq("sim_first_seg0", {25'd0, cap_seg[0]}, {25'd0, ~7'b0000110});
    check_eq("sim_first_seg3", {25'd0, cap_seg[3]}, {25'd0, ~7'b0000110});
    wait_frame(ncyc);
    capture_frame();
    check_eq("sim_next_seg0", {25'd0, cap_seg[0]}, {25'd0, ~7'b1011011});
    check_eq("sim_next_seg2", {25'd0, cap_seg[2]}, {25'd0, ~7'b1011011});

    // Leading-zero blanking
    blank_lz = 1'b1;
    load_main(16'h0030, 4'b1000);
    wait_frame(ncyc);
    capture_frame();
    check_eq("lz_seg3", {25'd0, cap_seg[3]}, 32'h7F);
    check_eq("lz_dp3",  {31'd0, cap_dp[3]},  32'd0);
    check_eq("lz_seg2", {25'd0, cap_seg[2]}, 32'h7F);
    check_eq("lz_seg1", {25'd0, cap_seg[1]}, {25'd0, ~7'b1001111});
    check_eq("lz_seg0", {25'd0, cap_seg[0]}, {25'd0, ~7'b0111111});
    load_main(16'h0000, 4'b0000);
    wait_frame(ncyc);
    capture_frame();
    check_eq("lz0_seg0", {25'd0, cap_seg[0]}, {25'd0, ~7'b0111111});
    check_eq("lz0_seg1", {25'd0, cap_seg[1]}, 32'h7F);
    blank_lz = 1'b0;

    // PWM duty
    brightness = 4'd0;
    wait_frame(ncyc);
    capture_frame();
    check_eq("pwm0_total", act_cnt,  32'd8);
    check_eq("pwm0_slot",  sel0_cnt, 32'd2);
    brightness = 4'd7;
    wait_frame(ncyc);
    capture_frame();
    check_eq("pwm7_total", act_cnt,  32'd64);
    check_eq("pwm7_slot",  sel0_cnt, 32'd16);
    brightness = 4'd15;
    wait_frame(ncyc);
    capture_frame();
    check_eq("pwm15_total", act_cnt,  32'd128);
    check_eq("pwm15_slot",  sel0_cnt, 32'd32);

    // Inverted-polarity instance
    load_p = 1'b1;
    @(negedge CLK);
    load_p  = 1'b0;
    found_p = 1'b0;
    for (int i = 0; i < 200 && !found_p; i++) begin
      @(negedge CLK);
      if (frame_p) found_p = 1'b1;
    end
    check_eq("p_frame_seen", {31'd0, found_p}, 32'd1);
    seen1_p = 1'b0;
    p_seg0  = 7'h00;
    p_seg1  = 7'h00;
    p_dp1   = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      if (sel_p == 2'b01) begin
        seen1_p = 1'b1;
        p_seg1  = seg_p;
        p_dp1   = dp_out_p;
      end
      if (sel_p == 2'b10) p_seg0 = seg_p;
    end
    check_eq("p_seen1", {31'd0, seen1_p}, 32'd1);
    check_eq("p_seg1",  {25'd0, p_seg1},  32'h7F);
    check_eq("p_dp1",   {31'd0, p_dp1},   32'd0);
    check_eq("p_seg0",  {25'd0, p_seg0},  {25'd0, 7'b1110111});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Parametrised successor to the two-digit seven-segment controller: time-multiplexes NUM_DIGITS hex digits onto one shared segment bus.
- Adds per-digit decimal points, leading-zero blanking, 16-level PWM brightness, tear-free double-buffered loads and selectable output polarity.
- Sits between CPU-visible IO registers and the Pmod pins in the icebreaker top.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (2..8); digit 0 is the least significant.
- DIV_BITS, 10, scan-divider width (>=5); one digit slot lasts 2^DIV_BITS cycles.
- SEG_ACTIVE_LOW, 1, 1 means seg_out and dp_out drive 0 to light a segment.
- SEL_ACTIVE_LOW, 0, 1 means digit_sel drives 0 to select a digit.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- din  in  4*NUM_DIGITS  hex nibbles; digit i is din[4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point for each digit.
- load  in  1  single-cycle strobe that captures din and dp_in into the pending buffer.
- blank_lz  in  1  enables leading-zero blanking.
- brightness  in  4  PWM level; 0 is the minimum (1/16), 15 is full on.
- seg_out  out  7  segments {g,f,e,d,c,b,a}; bit 0 is segment a.
- dp_out  out  1  decimal-point segment.
- digit_sel  out  NUM_DIGITS  one-hot digit enable.
- frame  out  1  one-cycle pulse when the pending buffer is copied to the active buffer.

Behaviour:
- Reset, asynchronous on RST_N low:
  - divider = 0, idx = 0, pending = 0, active = 0, frame = 0.
  - seg_out, dp_out and digit_sel all at their inactive level: all 1 if the matching ACTIVE_LOW parameter is 1, else all 0.
  - Reset asserted mid-scan takes effect immediately; there is no partial-frame recovery.
- Divider:
  - Free-running DIV_BITS counter, +1 every cycle, wraps to 0.
  - tick = (divider == all ones), combinational.
- Scan index:
  - On a tick edge, idx advances: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Load:
  - On an edge with load = 1: pending <= {dp_in, din}.
  - Back-to-back loads: the last one wins.
- Swap:
  - On a tick edge where idx == NUM_DIGITS-1: active <= pending and frame <= 1.
  - frame is 0 on all other edges.
  - If load and swap occur on the same edge, active takes the old pending value; the new data goes into pending and appears at the next swap.
  - Display latency after a load is at most NUM_DIGITS*2^DIV_BITS + 1 cycles.
- Blanking:
  - Digit i > 0 is blanked when blank_lz = 1 and active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit shows no segments, but its dp still follows its active dp bit.
- PWM:
  - pwm_on = (divider[DIV_BITS-1:DIV_BITS-4] <= brightness).
  - brightness = 15 gives 100% duty.
  - brightness is sampled live, not buffered.
- Outputs are registered, with one cycle of latency from idx/divider:
  - digit_sel <= pwm_on ? onehot(idx) : 0.
  - seg_out <= blanked ? 0 : font(active nibble[idx]).
  - dp_out <= active dp[idx].
  - Each output is inverted per its ACTIVE_LOW parameter.
  - Segments stay valid while the digit is PWM-off; only digit_sel gates.
- Font, raw active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Widths: idx is clog2(NUM_DIGITS) bits, minimum 1. No arithmetic overflow other than the intended divider wrap.

Test Plan:
- Reset and idle (NUM_DIGITS=4, DIV_BITS=5, defaults):
  - Hold RST_N low mid-run → next sample shows seg_out=7'h7F, dp_out=1, digit_sel=4'h0, frame=0.
  - After release, first frame pulse at cycle 4*32 = 128; active = 0.
- Load/swap latency:
  - Pulse load with din=16'h12AF, dp_in=4'b0100, brightness=15, blank_lz=0.
  - After the next frame pulse, the slot with digit_sel=4'b0001 shows seg_out=~7'b1110001 (F) and dp_out=1 (off).
  - The slot with digit_sel=4'b0100 shows seg_out=~7'b1011011 (2) and dp_out=0 (on).
- Simultaneous load and swap:
  - Load 16'h1111 early in the frame, then load 16'h2222 on the swap edge.
  - That frame displays 1111; the next frame displays 2222.
- Leading-zero blanking:
  - din=16'h0030, blank_lz=1 → digits 3 and 2 seg_out=7'h7F; digit 1 shows ~7'b1001111; digit 0 shows ~7'b0111111.
  - din=16'h0000 → digit 0 still shows 0.
- PWM:
  - brightness=0 → digit_sel active for exactly 2 of 32 cycles per slot (top4 == 0).
  - brightness=7 → active for 16 of 32 cycles.
  - brightness=15 → active for 32 of 32 cycles.
- Polarity, one bench:
  - NUM_DIGITS=2, SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=1, din=8'h8A.
  - Reset value is seg_out=0, digit_sel=2'b11.
  - During the digit-1 slot, digit_sel=2'b01 and seg_out=7'b1111111.
